// File: rtl/matrix2x2_operand_loader.sv
// Byte-serial loader for the 2x2 matrix multiply datapath: collects an 8-element
// frame (A then B, row-major) and presents packed a/b on a registered handshake.
module matrix2x2_operand_loader #(
  parameter int ELEM_W = 8,
  parameter int WORD_W = 4 * ELEM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] a,
  output logic [WORD_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic [2:0]        beat_cnt
);

  localparam logic COLLECT = 1'b0;
  localparam logic FULL    = 1'b1;

  logic              state_r;
  logic [WORD_W-1:0] stage_a_r, stage_b_r;
  logic [WORD_W-1:0] a_r, b_r;
  logic              out_valid_r, frame_err_r;
  logic [2:0]        beat_cnt_r;

  logic              accept_s, last_beat_s, err_s, done_s;
  logic              out_take_s, load_direct_s, load_stage_s;
  logic [WORD_W-1:0] stage_a_nxt_s, stage_b_nxt_s;

  // Element slot 0 sits in the most significant lane (a11/b11 at the top).
  function automatic logic [WORD_W-1:0] place(input logic [WORD_W-1:0] w,
                                              input logic [1:0] slot,
                                              input logic [ELEM_W-1:0] d);
    logic [WORD_W-1:0] r;
    r = w;
    case (slot)
      2'd0:    r[WORD_W-1          -: ELEM_W] = d;
      2'd1:    r[WORD_W-1-ELEM_W   -: ELEM_W] = d;
      2'd2:    r[WORD_W-1-2*ELEM_W -: ELEM_W] = d;
      2'd3:    r[WORD_W-1-3*ELEM_W -: ELEM_W] = d;
      default: r = w;
    endcase
    return r;
  endfunction

  assign in_ready = (state_r == COLLECT) && !flush;

  // Handshake decode and next staging contents including the current beat.
  always_comb begin
    accept_s      = in_valid && in_ready;
    last_beat_s   = (beat_cnt_r == 3'd7);
    err_s         = accept_s && (last_beat_s != in_last);
    done_s        = accept_s && last_beat_s && in_last;
    out_take_s    = out_valid_r && out_ready;
    load_direct_s = done_s && (!out_valid_r || out_take_s);
    load_stage_s  = (state_r == FULL) && out_take_s && !flush;
    if (accept_s && !beat_cnt_r[2]) begin
      stage_a_nxt_s = place(stage_a_r, beat_cnt_r[1:0], in_data);
      stage_b_nxt_s = stage_b_r;
    end else if (accept_s) begin
      stage_a_nxt_s = stage_a_r;
      stage_b_nxt_s = place(stage_b_r, beat_cnt_r[1:0], in_data);
    end else begin
      stage_a_nxt_s = stage_a_r;
      stage_b_nxt_s = stage_b_r;
    end
  end

  // Frame collection, staging buffer and framing-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= COLLECT;
      stage_a_r   <= {WORD_W{1'b0}};
      stage_b_r   <= {WORD_W{1'b0}};
      beat_cnt_r  <= 3'd0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= err_s;
      if (flush) begin
        state_r    <= COLLECT;
        stage_a_r  <= {WORD_W{1'b0}};
        stage_b_r  <= {WORD_W{1'b0}};
        beat_cnt_r <= 3'd0;
      end else if (err_s) begin
        stage_a_r  <= {WORD_W{1'b0}};
        stage_b_r  <= {WORD_W{1'b0}};
        beat_cnt_r <= 3'd0;
      end else if (done_s) begin
        stage_a_r  <= stage_a_nxt_s;
        stage_b_r  <= stage_b_nxt_s;
        beat_cnt_r <= 3'd0;
        state_r    <= load_direct_s ? COLLECT : FULL;
      end else if (accept_s) begin
        stage_a_r  <= stage_a_nxt_s;
        stage_b_r  <= stage_b_nxt_s;
        beat_cnt_r <= beat_cnt_r + 3'd1;
      end else if (load_stage_s) begin
        state_r <= COLLECT;
      end else begin
        state_r <= state_r;
      end
    end
  end

  // Output register: a/b only change on a load, never while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= {WORD_W{1'b0}};
      b_r         <= {WORD_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (load_direct_s) begin
      a_r         <= stage_a_nxt_s;
      b_r         <= stage_b_nxt_s;
      out_valid_r <= 1'b1;
    end else if (load_stage_s) begin
      a_r         <= stage_a_r;
      b_r         <= stage_b_r;
      out_valid_r <= 1'b1;
    end else if (out_take_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign a         = a_r;
  assign b         = b_r;
  assign out_valid = out_valid_r;
  assign frame_err = frame_err_r;
  assign beat_cnt  = beat_cnt_r;

endmodule

// File: tb/tb_matrix2x2_operand_loader.sv
// Directed bench for matrix2x2_operand_loader with hand-computed expectations.
module tb_matrix2x2_operand_loader;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, frame_err;
  logic [31:0] a, b;
  logic [2:0]  beat_cnt;
  int checks = 0;
  int failures = 0;

  matrix2x2_operand_loader dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends n beats base, base+1, ...; in_last on the beat at index last_idx.
  task automatic send(input logic [7:0] base, input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      in_data  = base + 8'(i);
      in_valid = 1'b1;
      in_last  = (i == last_idx);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_data = 8'h00;
    #12;
    chk("rst_a", a, 32'h0);
    chk("rst_b", b, 32'h0);
    chk("rst_ov", {31'd0, out_valid}, 32'h0);
    chk("rst_err", {31'd0, frame_err}, 32'h0);
    chk("rst_cnt", {29'd0, beat_cnt}, 32'h0);
    rst = 1'b0;
    tick();
    chk("rst_inrdy", {31'd0, in_ready}, 32'h1);

    // Frame with the output free.
    out_ready = 1'b1;
    send(8'h01, 8, 7);
    chk("t1_ov", {31'd0, out_valid}, 32'h1);
    chk("t1_a", a, 32'h01020304);
    chk("t1_b", b, 32'h05060708);
    chk("t1_err", {31'd0, frame_err}, 32'h0);
    tick();
    chk("t1_ov_drop", {31'd0, out_valid}, 32'h0);
    chk("t1_a_hold", a, 32'h01020304);

    // Back-pressure: second frame parks in staging.
    out_ready = 1'b0;
    send(8'h21, 8, 7);
    chk("t2_a1", a, 32'h21222324);
    send(8'h09, 8, 7);
    chk("t2_inrdy_full", {31'd0, in_ready}, 32'h0);
    chk("t2_cnt_full", {29'd0, beat_cnt}, 32'h0);
    chk("t2_a_held", a, 32'h21222324);
    in_data = 8'h77; in_valid = 1'b1;
    tick();
    chk("t2_stall_cnt", {29'd0, beat_cnt}, 32'h0);
    chk("t2_stall_a", a, 32'h21222324);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t2_a2", a, 32'h090A0B0C);
    chk("t2_b2", b, 32'h0D0E0F10);
    chk("t2_ov2", {31'd0, out_valid}, 32'h1);
    chk("t2_inrdy", {31'd0, in_ready}, 32'h1);
    chk("t2_cnt", {29'd0, beat_cnt}, 32'h0);
    tick();
    chk("t2_ov_drop", {31'd0, out_valid}, 32'h0);

    // Early in_last on beat index 2.
    send(8'h31, 3, 2);
    chk("t3_err", {31'd0, frame_err}, 32'h1);
    chk("t3_cnt", {29'd0, beat_cnt}, 32'h0);
    chk("t3_ov", {31'd0, out_valid}, 32'h0);
    tick();
    chk("t3_err_pulse", {31'd0, frame_err}, 32'h0);
    send(8'h01, 8, 7);
    chk("t3_a", a, 32'h01020304);
    chk("t3_b", b, 32'h05060708);
    chk("t3_ov2", {31'd0, out_valid}, 32'h1);
    tick();

    // Missing in_last on the 8th beat.
    send(8'h41, 8, 99);
    chk("t4_err", {31'd0, frame_err}, 32'h1);
    chk("t4_ov", {31'd0, out_valid}, 32'h0);
    chk("t4_cnt", {29'd0, beat_cnt}, 32'h0);
    chk("t4_a_hold", a, 32'h01020304);
    send(8'h51, 8, 7);
    chk("t4_err_clr", {31'd0, frame_err}, 32'h0);
    chk("t4_a", a, 32'h51525354);
    chk("t4_b", b, 32'h55565758);
    tick();

    // Flush mid-frame drops the concurrent beat.
    send(8'h61, 5, 99);
    chk("t5_cnt5", {29'd0, beat_cnt}, 32'h5);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    #1;
    chk("t5_inrdy", {31'd0, in_ready}, 32'h0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_cnt0", {29'd0, beat_cnt}, 32'h0);
    chk("t5_err", {31'd0, frame_err}, 32'h0);
    send(8'h11, 8, 7);
    chk("t5_a", a, 32'h11121314);
    chk("t5_b", b, 32'h15161718);
    tick();

    // Asynchronous reset mid-frame while the output is held.
    out_ready = 1'b0;
    send(8'h71, 8, 7);
    send(8'hA1, 3, 99);
    chk("t6_ov_pre", {31'd0, out_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_a", a, 32'h0);
    chk("t6_b", b, 32'h0);
    chk("t6_ov", {31'd0, out_valid}, 32'h0);
    chk("t6_cnt", {29'd0, beat_cnt}, 32'h0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t6_inrdy", {31'd0, in_ready}, 32'h1);
    send(8'h81, 8, 7);
    chk("t6_a2", a, 32'h81828384);
    chk("t6_b2", b, 32'h85868788);
    chk("t6_ov2", {31'd0, out_valid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
